regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, 16, register data width.
REQ-002 Parameter ADDR_W, 4, register address width (16 registers).
REQ-003 Parameter NREQ, 3, number of write requesters, fixed at 3 (0=ALU, 1=load, 2=vector unit).
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 req_valid  in  NREQ  per-requester write request.
REQ-007 req_addr  in  NREQ*ADDR_W  per-requester destination register, requester i in bits [i*ADDR_W +: ADDR_W].
REQ-008 req_data  in  NREQ*DATA_W  per-requester write data, packed the same way.
REQ-009 req_ready  out  NREQ  one-hot-or-zero grant; transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-010 stall  in  1  when 1, no grant is issued.
REQ-011 rsv_valid  in  1  reserve a destination register (instruction issued, result pending).
REQ-012 rsv_addr  in  ADDR_W  register to reserve.
REQ-013 regWrite  out  1  register-file write enable.
REQ-014 A3  out  ADDR_W  register-file write address.
REQ-015 WD3  out  DATA_W  register-file write data.
REQ-016 busy  out  16  per-register pending-write flags.
REQ-017 rsv_err  out  1  one-cycle pulse on an illegal reservation.

Function
REQ-018 req_ready SHALL be combinational from req_valid, stall and the round-robin pointer; it SHALL be all-zero when stall=1 or no req_valid bit is set.
REQ-019 Arbitration SHALL be round-robin: search order starts at (last_grant+1) mod 3 and wraps; the first requester with req_valid=1 is granted.
REQ-020 last_grant SHALL update only on a granted transfer; idle or stalled cycles leave it unchanged.
REQ-021 A transfer in cycle t SHALL produce regWrite=1, A3=req_addr[i], WD3=req_data[i] registered in cycle t+1 (latency 1).
REQ-022 In any cycle without a transfer, regWrite SHALL be 0 in the next cycle; A3 and WD3 SHALL hold their previous values.
REQ-023 At most one write SHALL be issued per cycle; back-to-back grants on consecutive cycles SHALL be supported at full throughput.
REQ-024 Requesters whose req_valid is deasserted before a grant SHALL be dropped without side effects; the arbiter SHALL keep no per-requester buffer.
REQ-025 A reservation (rsv_valid=1) in cycle t on a non-busy register SHALL set busy[rsv_addr] in cycle t+1.
REQ-026 A reservation on a register already busy SHALL leave busy unchanged and pulse rsv_err=1 in cycle t+1 for exactly one cycle.
REQ-027 A transfer to address a in cycle t SHALL clear busy[a] in cycle t+1.
REQ-028 Reservation and transfer to the same address in the same cycle: busy[a] SHALL stay 1 (reserve wins) and rsv_err SHALL stay 0.
REQ-029 A transfer to a non-busy register SHALL be performed normally; busy SHALL remain 0.
REQ-030 Two requesters targeting the same address in one cycle SHALL be serialized by round-robin; the first write clears busy.
REQ-031 stall SHALL NOT affect reservations or busy updates.

Reset
REQ-032 When rst=0 at posedge clk: regWrite=0, A3=0, WD3=0, busy=16'h0000, rsv_err=0, last_grant=2 (requester 0 has priority first).
REQ-033 Reset asserted mid-transfer SHALL discard the pending write: regWrite is 0 in the cycle after reset.
REQ-034 req_ready SHALL be all-zero while rst=0.

Verification
REQ-035 After reset, all three req_valid=1 for 4 cycles with stall=0: grants go 0,1,2,0; regWrite=1 in cycles 2-5 with A3 following each requester's addr.
REQ-036 rsv_valid=1, rsv_addr=5, then load writes addr 5 data 16'hBEEF: busy[5]=1 for one cycle, then regWrite=1, A3=5, WD3=16'hBEEF, and busy[5]=0 on the same edge.
REQ-037 Reserve addr 7 twice on consecutive cycles: busy[7]=1 and rsv_err=1 for exactly one cycle after the second reservation.
REQ-038 Same cycle: reserve addr 3 and ALU write to addr 3 while busy[3]=1: regWrite=1, A3=3, busy[3] stays 1, rsv_err=0.
REQ-039 stall=1 for 3 cycles with requester 1 valid: req_ready=0 and regWrite=0 throughout; after stall drops, requester 1 is granted in that cycle.
REQ-040 rst=0 in the cycle after a grant: regWrite=0, busy=0, and after release requester 0 wins a three-way tie.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for three result producers feeding one register-file write port,
// with a per-register scoreboard of pending writes.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREQ   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     stall,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic                     rsv_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [IDX_W-1:0]  lastGrant_q;
    logic [IDX_W-1:0]  grantIdx;
    logic [IDX_W:0]    candSum;
    logic [IDX_W-1:0]  cand;
    logic              xfer;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    logic              regWrite_q;
    logic [ADDR_W-1:0] a3_q;
    logic [DATA_W-1:0] wd3_q;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              rsvErr_q, rsvErr_d;

    // Search starts one past the last winner and wraps, so the first valid requester found wins.
    always_comb begin
        req_ready = '0;
        grantIdx  = lastGrant_q;
        xfer      = 1'b0;
        candSum   = '0;
        cand      = '0;
        if (rst && !stall) begin
            for (int k = 1; k <= NREQ; k++) begin
                candSum = {1'b0, lastGrant_q} + (IDX_W+1)'(k);
                if (candSum >= (IDX_W+1)'(NREQ)) begin
                    candSum = candSum - (IDX_W+1)'(NREQ);
                end
                cand = candSum[IDX_W-1:0];
                if (!xfer && req_valid[cand]) begin
                    req_ready[cand] = 1'b1;
                    grantIdx        = cand;
                    xfer            = 1'b1;
                end
            end
        end
    end

    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                selAddr = req_addr[i*ADDR_W +: ADDR_W];
                selData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A write that retires the very register being re-reserved frees it first, so that reservation is legal.
    always_comb begin
        busy_d   = busy_q;
        rsvErr_d = 1'b0;
        if (xfer) begin
            busy_d[selAddr] = 1'b0;
        end
        if (rsv_valid) begin
            if (busy_q[rsv_addr] && !(xfer && (selAddr == rsv_addr))) begin
                rsvErr_d = 1'b1;
            end else begin
                busy_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regWrite_q  <= 1'b0;
            a3_q        <= '0;
            wd3_q       <= '0;
            busy_q      <= '0;
            rsvErr_q    <= 1'b0;
            lastGrant_q <= IDX_W'(NREQ - 1);
        end else begin
            regWrite_q <= xfer;
            busy_q     <= busy_d;
            rsvErr_q   <= rsvErr_d;
            if (xfer) begin
                a3_q        <= selAddr;
                wd3_q       <= selData;
                lastGrant_q <= grantIdx;
            end
        end
    end

    assign regWrite = regWrite_q;
    assign A3       = a3_q;
    assign WD3      = wd3_q;
    assign busy     = busy_q;
    assign rsv_err  = rsvErr_q;

endmodule
